pipe_stage_skid_reg: RTL and testbench

//  Parametrised elastic pipeline-stage register, successor to the fixed ID->EXE latch.

---
 rtl/pipe_stage_skid_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register between two stages with valid/ready handshake.
// SKID_EN=1 adds a hidden skid entry so in_ready is a pure state decode.
module pipe_stage_skid_reg #(
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned DATA_W     = 128,
  parameter bit          SKID_EN    = 1'b1,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic acc;
  logic pop;
  logic load_head_in;
  logic load_head_skid;
  logic load_skid;
  logic clear_head;

  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign out_valid = (state != EMPTY);
  assign in_ready  = SKID_EN ? (state != FULL2) : (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occ       = 2'(state);
  assign out_ctrl  = head_ctrl;
  assign out_data  = head_data;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath steering.
  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    clear_head     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && !pop && SKID_EN) begin
          state_nxt = FULL2;
          load_skid = 1'b1;
        end else if (acc && pop) begin
          load_head_in = 1'b1;
        end else if (pop) begin
          state_nxt  = EMPTY;
          clear_head = 1'b1;
        end
      end
      FULL2: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Head control is cleared whenever the stage empties so out_ctrl is 0 while idle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        head_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_head_in) begin
        head_ctrl <= in_ctrl;
        head_data <= in_data;
      end else if (load_head_skid) begin
        head_ctrl <= skid_ctrl;
        head_data <= skid_data;
      end else if (clear_head) begin
        head_ctrl <= '0;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench: one skid instance and one single-entry instance share the stimulus;
// each has its own expected-entry queue drained by a separate monitor.
module tb_pipe_stage_skid_reg;

  typedef struct packed {
    logic [7:0]   ctrl;
    logic [127:0] data;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0]   out_ctrl1, out_ctrl0;
  logic [127:0] out_data1, out_data0;
  logic [1:0]   occ1, occ0;

  int n_cmp = 0;
  int n_err = 0;

  item_t q1[$];
  item_t q0[$];
  logic  pend1 = 1'b0;
  logic  pend0 = 1'b0;
  item_t pend_item = '0;
  logic  clr1 = 1'b0;
  logic  clr0 = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(128), .SKID_EN(1'b1), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occ(occ1)
  );

  pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(128), .SKID_EN(1'b0), .CLEAR_DATA(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occ(occ0)
  );

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; records which instance accepted the driven entry.
  task automatic step(input logic r, input logic fl, input logic iv, input logic [7:0] c,
                      input logic [127:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    #1;
    pend_item = '{ctrl: c, data: d};
    pend1     = iv && in_ready1 && !fl && !r;
    pend0     = iv && in_ready0 && !fl && !r;
  endtask

  // Monitor for the skid instance.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      q1.delete();
      clr1 = 1'b1;
    end else begin
      chk("occ1", 136'(occ1), 136'(q1.size()));
      chk("out_valid1", 136'(out_valid1), 136'(q1.size() != 0));
      chk("in_ready1", 136'(in_ready1), 136'(q1.size() < 2));
      if (clr1) chk("data_clear1", 136'(out_data1), 136'(0));
      clr1 = 1'b0;
      if (out_valid1 && q1.size() > 0) begin
        chk("out_ctrl1", 136'(out_ctrl1), 136'(q1[0].ctrl));
        chk("out_data1", 136'(out_data1), 136'(q1[0].data));
      end else if (!out_valid1) begin
        chk("idle_ctrl1", 136'(out_ctrl1), 136'(0));
      end
      if (out_valid1 && out_ready && q1.size() > 0) void'(q1.pop_front());
      if (flush) begin
        q1.delete();
        clr1 = 1'b1;
      end else if (pend1) begin
        q1.push_back(pend_item);
      end
    end
  end

  // Monitor for the single-entry instance.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      q0.delete();
      clr0 = 1'b1;
    end else begin
      chk("occ0", 136'(occ0), 136'(q0.size()));
      chk("out_valid0", 136'(out_valid0), 136'(q0.size() != 0));
      chk("in_ready0", 136'(in_ready0), 136'(q0.size() == 0 || out_ready));
      if (clr0) chk("data_clear0", 136'(out_data0), 136'(0));
      clr0 = 1'b0;
      if (out_valid0 && q0.size() > 0) begin
        chk("out_ctrl0", 136'(out_ctrl0), 136'(q0[0].ctrl));
        chk("out_data0", 136'(out_data0), 136'(q0[0].data));
      end else if (!out_valid0) begin
        chk("idle_ctrl0", 136'(out_ctrl0), 136'(0));
      end
      if (out_valid0 && out_ready && q0.size() > 0) void'(q0.pop_front());
      if (flush) begin
        q0.delete();
        clr0 = 1'b1;
      end else if (pend0) begin
        q0.push_back(pend_item);
      end
    end
  end

  initial begin
    // Reset held two cycles with an entry offered.
    step(1'b1, 1'b0, 1'b1, 8'hAA, 128'hDEAD, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'hAA, 128'hDEAD, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);
    chk("t1_in_ready1", 136'(in_ready1), 136'(1));
    chk("t1_occ1", 136'(occ1), 136'(0));

    // Streaming: data=i on consecutive cycles.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'(i + 1), 128'(i), 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);

    // Back-pressure: A then B with downstream stalled, then drain.
    step(1'b0, 1'b0, 1'b1, 8'h11, 128'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h22, 128'hB, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b0);
    chk("t3_occ1", 136'(occ1), 136'(2));
    chk("t3_in_ready1", 136'(in_ready1), 136'(0));
    chk("t3_head1", 136'(out_data1), 136'(128'hA));
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);

    // Flush while full with C offered; C must never appear.
    step(1'b0, 1'b0, 1'b1, 8'h33, 128'hA1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h44, 128'hB1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h55, 128'hC1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);
    chk("t4_occ1", 136'(occ1), 136'(0));
    chk("t4_ctrl1", 136'(out_ctrl1), 136'(0));
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);

    // Flush discards a same-cycle accepted input.
    step(1'b0, 1'b0, 1'b1, 8'h66, 128'hD0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h77, 128'hD1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);

    // Single-entry instance: accept while popping replaces the head.
    step(1'b0, 1'b0, 1'b1, 8'h88, 128'hE0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h99, 128'hE1, 1'b1);
    chk("t5_in_ready0", 136'(in_ready0), 136'(1));
    chk("t5_occ0", 136'(occ0), 136'(1));
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b0);
    chk("t5_head0", 136'(out_data0), 136'(128'hE1));
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);

    // Random valid/ready/flush traffic.
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, ($urandom % 32) == 0, 1'($urandom % 2), 8'($urandom),
           {$urandom, $urandom, $urandom, $urandom}, ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b1);
    chk("drain_q1", 136'(q1.size()), 136'(0));
    chk("drain_q0", 136'(q0.size()), 136'(0));

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
